// File: rtl/ahb_slv_pkg.sv
// ahb_slv_pkg: AHB encodings, slave FSM states and byte-lane helper for ahb_sram_slave.
// Rev 1.0
`default_nettype none

package ahb_slv_pkg;

  localparam logic [1:0] c_htrans_idle   = 2'd0;
  localparam logic [1:0] c_htrans_busy   = 2'd1;
  localparam logic [1:0] c_htrans_nonseq = 2'd2;
  localparam logic [1:0] c_htrans_seq    = 2'd3;

  localparam logic [2:0] c_hsize_byte = 3'd0;
  localparam logic [2:0] c_hsize_half = 3'd1;
  localparam logic [2:0] c_hsize_word = 3'd2;

  localparam logic [1:0] c_hresp_okay  = 2'd0;
  localparam logic [1:0] c_hresp_error = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Little-endian byte enables for a naturally aligned transfer.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] mask;
    case (size)
      c_hsize_byte: mask = 4'b0001 << addr;
      c_hsize_half: mask = addr[1] ? 4'b1100 : 4'b0011;
      default:      mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_slv_mem.sv
// ahb_slv_mem: DEPTH x 32 word array, synchronous byte-enabled write, asynchronous read.
// Rev 1.0
`default_nettype none

module ahb_slv_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with error checking and optional wait states
// (wait states enabled by defining AHB_SLV_WAIT_EN). Rev 1.0
`default_nettype none

module ahb_sram_slave
  import ahb_slv_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp
);

  localparam int unsigned c_aw    = $clog2(DEPTH);
  localparam logic [31:0] c_limit = 32'(DEPTH) << 2;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_aw+1:0] r_addr;
  logic            r_write;
  logic [2:0]      r_size;
  logic            r_pend;

  logic        w_accept;
  logic        w_err;
  logic        w_ready;
  logic        w_done;
  logic [3:0]  w_we;
  logic [31:0] w_rdata;
  state_t      w_okay_state;

  assign w_accept = hsel & hready & htrans[1];
  assign w_err    = (hsize > c_hsize_word)
                  | ((hsize == c_hsize_half) & haddr[0])
                  | ((hsize == c_hsize_word) & (haddr[1:0] != 2'b00))
                  | (haddr >= c_limit);

`ifdef AHB_SLV_WAIT_EN
  logic [2:0] r_cnt;

  assign w_okay_state = (WAIT_STATES > 0) ? ST_WAIT : ST_IDLE;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_cnt <= 3'd0;
    end else if (w_ready && w_accept && !w_err) begin
      r_cnt <= 3'(WAIT_STATES);
    end else if (r_state == ST_WAIT && r_cnt != 3'd0) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end
`else
  assign w_okay_state = ST_IDLE;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    hresp       = c_hresp_okay;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_IDLE;
      ST_WAIT: begin
        w_ready = 1'b0;
`ifdef AHB_SLV_WAIT_EN
        if (r_cnt <= 3'd1) w_state_nxt = ST_IDLE;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_ERR1: begin
        w_ready     = 1'b0;
        hresp       = c_hresp_error;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        hresp       = c_hresp_error;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // The final data-phase cycle doubles as the next address phase.
    if (w_ready && w_accept) w_state_nxt = w_err ? ST_ERR1 : w_okay_state;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ready) begin
        r_pend <= w_accept & ~w_err;
        if (w_accept) begin
          r_addr  <= haddr[c_aw+1:0];
          r_write <= hwrite;
          r_size  <= hsize;
        end
      end
    end
  end

  // r_pend is only set for OKAY transfers, so ready+pend marks the completing cycle.
  assign w_done    = r_pend & w_ready;
  assign w_we      = (w_done & r_write) ? lane_mask(r_size, r_addr[1:0]) : 4'b0000;
  assign hrdata    = (w_done & ~r_write) ? w_rdata : 32'h0;
  assign hreadyout = w_ready;

  ahb_slv_mem #(
    .DEPTH (DEPTH),
    .AW    (c_aw)
  ) u_mem (
    .clk     (hclk),
    .i_we    (w_we),
    .i_addr  (r_addr[c_aw+1:2]),
    .i_wdata (hwdata),
    .o_rdata (w_rdata)
  );

endmodule

`default_nettype wire

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit memory words (power of two, 16..4096).
REQ-002 Parameter WAIT_STATES, default 2, wait cycles inserted per OKAY transfer (0..7).
REQ-003 Port hclk  input  1  single clock; all state updates on rising edge.
REQ-004 Port hreset  input  1  asynchronous, active-high reset.
REQ-005 Port hsel  input  1  slave select.
REQ-006 Port haddr  input  32  byte address.
REQ-007 Port htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 Port hwrite  input  1  1=write, 0=read.
REQ-009 Port hsize  input  3  0=byte, 1=halfword, 2=word.
REQ-010 Port hburst  input  3  burst type; ignored except for pass-through to monitor.
REQ-011 Port hprot  input  4  ignored.
REQ-012 Port hready  input  1  bus-level ready; an address phase is accepted only when high.
REQ-013 Port hwdata  input  32  write data, valid in data phase.
REQ-014 Port hrdata  output  32  read data.
REQ-015 Port hreadyout  output  1  slave ready.
REQ-016 Port hresp  output  2  OKAY=0, ERROR=1.

Function
REQ-017 Transfer accepted when hsel & hready & htrans[1] on a rising edge; haddr, hwrite, hsize are registered at that edge.
REQ-018 IDLE/BUSY, or hsel low, SHALL produce a zero-wait OKAY response (hreadyout=1, hresp=0).
REQ-019 FSM states: IDLE, WAIT, ERR1, ERR2; IDLE is the data-phase-complete/no-transfer state.
REQ-020 Accepted valid transfer with WAIT_STATES=N>0: IDLE->WAIT, hreadyout=0 for exactly N cycles, then hreadyout=1 for one cycle (OKAY), FSM back to IDLE; N=0 completes in the first data-phase cycle.
REQ-021 Error conditions: hsize>2; halfword with haddr[0]=1; word with haddr[1:0]!=0; haddr>=DEPTH*4.
REQ-022 Error transfer: ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), then IDLE; no wait states; memory unchanged; hrdata=0.
REQ-023 Write: memory updated at the final data-phase edge (hreadyout=1) using hwdata; byte lanes selected by registered hsize and haddr[1:0], little-endian.
REQ-024 Read: hrdata carries the full addressed word during the cycle hreadyout=1; hrdata=0 otherwise.
REQ-025 New address phase accepted in the final data-phase cycle (pipelined, back-to-back transfers with no idle cycle).
REQ-026 Read immediately following a write to the same word SHALL return the merged new data (write-to-read forwarding).
REQ-027 Transfers presented while hreadyout=0 are ignored (hready low).

Reset
REQ-028 hreset high asynchronously forces FSM=IDLE, wait counter=0, hreadyout=1, hresp=0, hrdata=0, registered address-phase control cleared.
REQ-029 Reset mid-transfer SHALL abort it; a pending write is discarded; memory contents are not cleared.

Configuration
REQ-030 Macro AHB_SLV_WAIT_EN defined: WAIT state and 3-bit wait counter present, behaviour per REQ-020.
REQ-031 AHB_SLV_WAIT_EN undefined: WAIT_STATES ignored, every OKAY transfer completes zero-wait; error behaviour unchanged.

Structure
REQ-032 Package ahb_slv_pkg holds htrans/hsize/hresp encodings, FSM state enum, and the byte-lane-mask function.
REQ-033 Sub-module ahb_slv_mem: DEPTH x 32 synchronous-write, asynchronous-read array with 4-bit byte write enable.

Verification
REQ-034 Reset, WAIT_STATES=2: word write 0xDEADBEEF to 0x10, then read 0x10 -> 2 wait cycles each, hrdata=0xDEADBEEF, hresp=0.
REQ-035 Byte write 0xAA to 0x21 over word 0x11223344 at 0x20 -> read 0x20 returns 0x1122AA44.
REQ-036 Word read at 0x02 -> ERR1 then ERR2 (hresp=1 both cycles, hreadyout 0 then 1); memory unchanged.
REQ-037 Read at 0x400 with DEPTH=256 -> two-cycle ERROR response, hrdata=0.
REQ-038 Back-to-back write 0x12345678 to 0x30 then NONSEQ read 0x30, WAIT_STATES=0 -> read returns 0x12345678 with no idle cycle.
REQ-039 hreset asserted during the WAIT of a write to 0x40 -> hreadyout=1 immediately; subsequent read of 0x40 returns its prior value.
